// File: rtl/binary_div_19_10_bi_pkg.sv
// Shared types and widths for the sequential signed divider.
// Widths default to the 10x10 multiplier product (19 bits) and its operand (10 bits).
package binary_div_pkg;

  localparam int W_N   = 19;
  localparam int W_D   = 10;
  localparam int CNT_W = $clog2(W_N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/binary_div_19_10_bi_if.sv
// Request/result bundle between the divider and its user.
// The master drives operands and start; the slave (divider) returns the result and status.
interface binary_div_19_10_bi_if;
  import binary_div_pkg::*;

  logic                  en;
  logic                  start;
  logic signed [W_N-1:0] N;
  logic signed [W_D-1:0] D;
  logic signed [W_N-1:0] Q;
  logic signed [W_D-1:0] R;
  logic                  busy;
  logic                  done;
  logic                  dbz;
  logic                  ovf;

  modport master (
    output en, start, N, D,
    input  Q, R, busy, done, dbz, ovf
  );

  modport slave (
    input  en, start, N, D,
    output Q, R, busy, done, dbz, ovf
  );

endinterface

// File: rtl/binary_div_19_10_bi_step.sv
// One combinational restoring-division step on magnitudes.
// Shifts the next dividend bit into the partial remainder and subtracts |D| when it fits.
module binary_div_step
  import binary_div_pkg::*;
(
  input  logic [W_D:0]   rem_i,
  input  logic           bit_i,
  input  logic [W_D-1:0] dmag_i,
  output logic [W_D:0]   rem_o,
  output logic           q_bit_o
);

  logic [W_D+1:0] rem_sh;
  logic [W_D+1:0] dmag_ext;

  always_comb begin
    rem_sh   = {rem_i, bit_i};
    dmag_ext = {2'b00, dmag_i};
    q_bit_o  = (rem_sh >= dmag_ext);
    // The partial remainder stays below |D| <= 2^(W_D-1), so W_D+1 bits always hold it.
    rem_o    = (W_D+1)'(q_bit_o ? (rem_sh - dmag_ext) : rem_sh);
  end

endmodule

// File: rtl/binary_div_19_10_bi.sv
// Sequential signed divider: radix-2 restoring iteration on magnitudes, then sign fix-up.
// Quotient truncates toward zero; remainder takes the dividend's sign.
module binary_div_19_10_bi
  import binary_div_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  binary_div_19_10_bi_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(W_N - 1);
  localparam logic [CNT_W-1:0] CNT_END  = '1;
  localparam logic [W_N-1:0]   N_MIN    = {1'b1, {(W_N-1){1'b0}}};

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [W_N-1:0]        num_q;
  logic [W_N-1:0]        quo_q;
  logic [W_D:0]          rem_q;
  logic [W_D-1:0]        dmag_q;
  logic                  qneg_q, rneg_q, ovf_case_q;
  logic signed [W_N-1:0] q_out_q;
  logic signed [W_D-1:0] r_out_q;
  logic                  dbz_q, ovf_q;

  logic                  accept;
  logic                  d_zero;
  logic [W_N-1:0]        n_abs;
  logic [W_D-1:0]        d_abs;
  logic [W_D:0]          step_rem;
  logic                  step_q;

  assign accept = bus.en && bus.start && (state_q == IDLE || state_q == DONE);
  assign d_zero = (bus.D == '0);
  assign n_abs  = bus.N[W_N-1] ? (~bus.N + W_N'(1)) : bus.N;
  assign d_abs  = bus.D[W_D-1] ? (~bus.D + W_D'(1)) : bus.D;

  binary_div_step u_step (
    .rem_i   (rem_q),
    .bit_i   (num_q[W_N-1]),
    .dmag_i  (dmag_q),
    .rem_o   (step_rem),
    .q_bit_o (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // CALC spends one extra cycle after the last step (counter wrapped) before FIX.
  always_comb begin
    state_d = state_q;
    if (bus.en) begin
      case (state_q)
        IDLE, DONE: if (bus.start) state_d = d_zero ? DONE : CALC;
        CALC:       if (cnt_q == CNT_END) state_d = FIX;
        FIX:        state_d = DONE;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      CALC, FIX: bus.busy = 1'b1;
      DONE:      bus.done = 1'b1;
      default:   ;
    endcase
  end

  assign bus.Q   = q_out_q;
  assign bus.R   = r_out_q;
  assign bus.dbz = dbz_q;
  assign bus.ovf = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      num_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dmag_q     <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      ovf_case_q <= 1'b0;
      q_out_q    <= '0;
      r_out_q    <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (bus.en) begin
      if (accept) begin
        cnt_q      <= CNT_LOAD;
        num_q      <= n_abs;
        quo_q      <= '0;
        rem_q      <= '0;
        dmag_q     <= d_abs;
        qneg_q     <= bus.N[W_N-1] ^ bus.D[W_D-1];
        rneg_q     <= bus.N[W_N-1];
        ovf_case_q <= (bus.N == N_MIN) && (bus.D == '1);
        q_out_q    <= '0;
        r_out_q    <= '0;
        dbz_q      <= d_zero;
        ovf_q      <= 1'b0;
      end else if (state_q == CALC) begin
        if (cnt_q != CNT_END) begin
          rem_q <= step_rem;
          quo_q <= {quo_q[W_N-2:0], step_q};
          num_q <= {num_q[W_N-2:0], 1'b0};
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end else if (state_q == FIX) begin
        // -2^(W_N-1) / -1 gives magnitude 2^(W_N-1), which wraps back to the minimum.
        q_out_q <= qneg_q ? (~quo_q + W_N'(1)) : quo_q;
        r_out_q <= rneg_q ? (~rem_q[W_D-1:0] + W_D'(1)) : rem_q[W_D-1:0];
        ovf_q   <= ovf_case_q;
      end
    end
  end

endmodule

// File: tb/tb_binary_div_19_10_bi.sv
// Directed checks of the sequential signed divider: signs, round trips, edge cases,
// clock-enable stalls, ignored starts, async abort and back-to-back operation.
module tb_binary_div_19_10_bi;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  binary_div_19_10_bi_if bus ();

  binary_div_19_10_bi dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Launch one division from just after a rising edge; returns enabled+stalled cycles until done.
  task automatic run_op(input logic signed [18:0] n, input logic signed [9:0] d,
                        output int lat, output logic done_at_accept);
    bus.N     = n;
    bus.D     = d;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start      = 1'b0;
    done_at_accept = bus.done;
    lat            = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.done) break;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.en    = 1'b1;
    bus.start = 1'b0;
    bus.N     = '0;
    bus.D     = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({bus.Q, bus.R, bus.busy, bus.done, bus.dbz, bus.ovf} !== 33'd0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got Q=%0d R=%0d busy=%b done=%b dbz=%b ovf=%b, want all 0",
                 c, bus.Q, bus.R, bus.busy, bus.done, bus.dbz, bus.ovf);
      end
    end
    $display("reset: idle outputs checked for 5 cycles");
  endtask

  task automatic test_signs();
    logic signed [18:0] tn[4] = '{19'sd100, -19'sd100, 19'sd100, -19'sd100};
    logic signed [9:0]  td[4] = '{10'sd7, 10'sd7, -10'sd7, -10'sd7};
    logic signed [18:0] tq[4] = '{19'sd14, -19'sd14, -19'sd14, 19'sd14};
    logic signed [9:0]  tr[4] = '{10'sd2, -10'sd2, 10'sd2, -10'sd2};
    int   lat;
    logic d0;
    for (int k = 0; k < 4; k++) begin
      run_op(tn[k], td[k], lat, d0);
      $display("op %0d / %0d -> Q=%0d R=%0d lat=%0d", tn[k], td[k], bus.Q, bus.R, lat);
      checks++;
      if (lat !== 21) begin
        errors++;
        $display("FAIL signs_latency %0d/%0d: got %0d cycles, want 21", tn[k], td[k], lat);
      end
      checks++;
      if (bus.Q !== tq[k] || bus.R !== tr[k]) begin
        errors++;
        $display("FAIL signs_result %0d/%0d: got Q=%0d R=%0d, want Q=%0d R=%0d",
                 tn[k], td[k], bus.Q, bus.R, tq[k], tr[k]);
      end
      checks++;
      if (bus.dbz !== 1'b0 || bus.ovf !== 1'b0) begin
        errors++;
        $display("FAIL signs_flags %0d/%0d: got dbz=%b ovf=%b, want 0 0", tn[k], td[k], bus.dbz, bus.ovf);
      end
    end
  endtask

  task automatic test_roundtrip();
    logic signed [18:0] tn[2] = '{19'sd261121, -19'sd261632};
    logic signed [9:0]  td[2] = '{-10'sd511, 10'sd511};
    logic signed [18:0] tq[2] = '{-19'sd511, -19'sd512};
    int   lat;
    logic d0;
    int   i, j, bad;
    for (int k = 0; k < 2; k++) begin
      run_op(tn[k], td[k], lat, d0);
      $display("op %0d / %0d -> Q=%0d R=%0d lat=%0d", tn[k], td[k], bus.Q, bus.R, lat);
      checks++;
      if (bus.Q !== tq[k] || bus.R !== 10'sd0 || lat !== 21) begin
        errors++;
        $display("FAIL roundtrip %0d/%0d: got Q=%0d R=%0d lat=%0d, want Q=%0d R=0 lat=21",
                 tn[k], td[k], bus.Q, bus.R, lat, tq[k]);
      end
    end
    bad = 0;
    for (int s = 0; s < 2000; s++) begin
      do begin
        i = int'($urandom_range(1023)) - 512;
        j = int'($urandom_range(1023)) - 512;
      end while (j == 0 || (i == -512 && j == -512));
      run_op(19'(i * j), 10'(j), lat, d0);
      checks++;
      if (bus.Q !== 19'(i) || bus.R !== 10'sd0 || bus.done !== 1'b1) begin
        errors++;
        bad++;
        $display("FAIL sweep %0d*%0d / %0d: got Q=%0d R=%0d done=%b, want Q=%0d R=0 done=1",
                 i, j, j, bus.Q, bus.R, bus.done, i);
      end
    end
    $display("sweep: 2000 products divided back, %0d wrong", bad);
  endtask

  task automatic test_edges();
    int   lat;
    logic d0;
    run_op(-19'sd262144, -10'sd1, lat, d0);
    $display("op -262144 / -1 -> Q=%0d R=%0d ovf=%b lat=%0d", bus.Q, bus.R, bus.ovf, lat);
    checks++;
    if (bus.ovf !== 1'b1 || bus.Q !== -19'sd262144 || bus.R !== 10'sd0 || bus.dbz !== 1'b0 || lat !== 21) begin
      errors++;
      $display("FAIL overflow: got ovf=%b dbz=%b Q=%0d R=%0d lat=%0d, want ovf=1 dbz=0 Q=-262144 R=0 lat=21",
               bus.ovf, bus.dbz, bus.Q, bus.R, lat);
    end
    run_op(19'sd55, 10'sd0, lat, d0);
    $display("op 55 / 0 -> Q=%0d R=%0d dbz=%b lat=%0d", bus.Q, bus.R, bus.dbz, lat);
    checks++;
    if (bus.dbz !== 1'b1 || bus.ovf !== 1'b0 || bus.Q !== 19'sd0 || bus.R !== 10'sd0 || lat !== 1) begin
      errors++;
      $display("FAIL div_by_zero: got dbz=%b ovf=%b Q=%0d R=%0d lat=%0d, want dbz=1 ovf=0 Q=0 R=0 lat=1",
               bus.dbz, bus.ovf, bus.Q, bus.R, lat);
    end
    run_op(19'sd5, -10'sd512, lat, d0);
    $display("op 5 / -512 -> Q=%0d R=%0d lat=%0d", bus.Q, bus.R, lat);
    checks++;
    if (bus.Q !== 19'sd0 || bus.R !== 10'sd5 || bus.dbz !== 1'b0 || lat !== 21) begin
      errors++;
      $display("FAIL small_over_min: got Q=%0d R=%0d dbz=%b lat=%0d, want Q=0 R=5 dbz=0 lat=21",
               bus.Q, bus.R, bus.dbz, lat);
    end
  endtask

  task automatic test_en_stall();
    int lat;
    bus.N     = 19'sd1000;
    bus.D     = -10'sd13;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    repeat (5) begin
      @(posedge clk);
      lat++;
    end
    #1 bus.en = 1'b0;
    repeat (4) begin
      @(posedge clk);
      lat++;
    end
    #1;
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold: got busy=%b done=%b, want busy=1 done=0", bus.busy, bus.done);
    end
    bus.en = 1'b1;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.done) break;
    end
    $display("op 1000 / -13 with 4-cycle stall -> Q=%0d R=%0d lat=%0d", bus.Q, bus.R, lat);
    checks++;
    if (lat !== 25 || bus.Q !== -19'sd76 || bus.R !== 10'sd12) begin
      errors++;
      $display("FAIL stall_result: got Q=%0d R=%0d lat=%0d, want Q=-76 R=12 lat=25", bus.Q, bus.R, lat);
    end
  endtask

  task automatic test_start_busy();
    int lat;
    bus.N     = 19'sd300;
    bus.D     = -10'sd9;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    repeat (6) begin
      @(posedge clk);
      lat++;
    end
    #1;
    bus.N     = 19'sd7;
    bus.D     = 10'sd1;
    bus.start = 1'b1;
    @(posedge clk);
    lat++;
    #1 bus.start = 1'b0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.done) break;
    end
    $display("op 300 / -9 with stray start -> Q=%0d R=%0d lat=%0d", bus.Q, bus.R, lat);
    checks++;
    if (lat !== 21 || bus.Q !== -19'sd33 || bus.R !== 10'sd3) begin
      errors++;
      $display("FAIL start_busy: got Q=%0d R=%0d lat=%0d, want Q=-33 R=3 lat=21", bus.Q, bus.R, lat);
    end
  endtask

  task automatic test_abort();
    bus.N     = 19'sd100;
    bus.D     = 10'sd7;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    $display("abort mid-CALC -> busy=%b done=%b Q=%0d", bus.busy, bus.done, bus.Q);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Q !== 19'sd0 || bus.R !== 10'sd0) begin
      errors++;
      $display("FAIL abort_now: got busy=%b done=%b Q=%0d R=%0d, want 0 0 0 0", bus.busy, bus.done, bus.Q, bus.R);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_back_to_back();
    int   lat;
    logic d0;
    run_op(19'sd100, 10'sd7, lat, d0);
    checks++;
    if (bus.done !== 1'b1 || bus.Q !== 19'sd14 || bus.R !== 10'sd2) begin
      errors++;
      $display("FAIL b2b_first: got done=%b Q=%0d R=%0d, want done=1 Q=14 R=2", bus.done, bus.Q, bus.R);
    end
    run_op(-19'sd999, 10'sd10, lat, d0);
    $display("op -999 / 10 back-to-back -> Q=%0d R=%0d lat=%0d", bus.Q, bus.R, lat);
    checks++;
    if (d0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_drop: got done=%b after accept, want 0", d0);
    end
    checks++;
    if (lat !== 21 || bus.Q !== -19'sd99 || bus.R !== -10'sd9) begin
      errors++;
      $display("FAIL b2b_second: got Q=%0d R=%0d lat=%0d, want Q=-99 R=-9 lat=21", bus.Q, bus.R, lat);
    end
  endtask

  initial begin
    test_reset();
    test_signs();
    test_roundtrip();
    test_edges();
    test_en_stall();
    test_start_busy();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
